// File: rtl/fifo_to_axis_packetizer.sv
// fifo_to_axis_packetizer
//   Pops words from an upstream first-word-fall-through FIFO and emits them on
//   an AXI-Stream master port, framed into packets of PKT_LEN words with tlast
//   on the final word. A 2-entry output buffer decouples the FIFO read from
//   m_axis_tready, so the read strobe never depends on tready yet one beat per
//   cycle is still sustained.
//
// Ports
//   clk            : sole clock, rising edge
//   reset_n        : synchronous active-low reset
//   enable         : permits new packets to start (packets in flight finish)
//   fifo_rd_en     : pop strobe to the upstream FIFO
//   fifo_rd_data   : FIFO head word, valid while fifo_empty_n=1
//   fifo_empty_n   : FIFO holds at least one word
//   m_axis_tdata   : stream data (oldest buffered word)
//   m_axis_tvalid  : stream valid (buffer non-empty)
//   m_axis_tready  : stream ready
//   m_axis_tlast   : final beat of a packet
//   pkt_count      : completed packets, wraps modulo 2^CNT_WIDTH
//   busy           : packet in progress or buffer holds data
module fifo_to_axis_packetizer #(
  parameter int DATA_WIDTH = 32,
  parameter int PKT_LEN    = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_empty_n,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic                  busy
);

  localparam int IDX_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                 state;
  logic [1:0]             occ;
  logic [IDX_W-1:0]       word_idx;

  // Output buffer: _p0 is the oldest entry (presented on m_axis), _p1 the newer.
  logic [DATA_WIDTH-1:0]  data_p0;
  logic [DATA_WIDTH-1:0]  data_p1;
  logic                   last_p0;
  logic                   last_p1;

  logic                   at_first;
  logic                   at_last;
  logic                   pop;
  logic                   xfer;
  logic                   wr_slot0;

  assign at_first = (word_idx == '0);
  assign at_last  = (word_idx == LAST_IDX);

  // At a packet boundary with enable low, no new packet may start, so the pop
  // is suppressed in that cycle while the FSM falls back to IDLE.
  assign pop  = fifo_empty_n && (state == RUN) && (occ != 2'd2) && !(at_first && !enable);
  assign xfer = (occ != 2'd0) && m_axis_tready;

  // A new word lands in the head slot when the buffer is (or is becoming) empty.
  assign wr_slot0 = (occ == 2'd0) || ((occ == 2'd1) && xfer);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      occ       <= 2'd0;
      word_idx  <= '0;
      pkt_count <= '0;
      data_p0   <= '0;
      last_p0   <= 1'b0;
    end else begin
      occ <= occ + {1'b0, pop} - {1'b0, xfer};

      if (pop)
        word_idx <= at_last ? '0 : word_idx + 1'b1;

      if (xfer && last_p0)
        pkt_count <= pkt_count + 1'b1;

      unique case (state)
        IDLE: if (enable) state <= RUN;
        RUN:  if (!enable && (at_first || (pop && at_last))) state <= IDLE;
      endcase

      // Shift on transfer first; a simultaneous pop below overrides the slot it fills.
      if (xfer) begin
        data_p0 <= data_p1;
        last_p0 <= last_p1;
      end
      if (pop) begin
        if (wr_slot0) begin
          data_p0 <= fifo_rd_data;
          last_p0 <= at_last;
        end else begin
          data_p1 <= fifo_rd_data;
          last_p1 <= at_last;
        end
      end
    end
  end

  assign fifo_rd_en    = pop;
  assign m_axis_tvalid = (occ != 2'd0);
  assign m_axis_tdata  = data_p0;
  assign m_axis_tlast  = last_p0;
  assign busy          = (state == RUN) || (occ != 2'd0);

endmodule

// File: tb/tb_fifo_to_axis_packetizer.sv
// Testbench for fifo_to_axis_packetizer: instance "a" uses PKT_LEN=4,
// CNT_WIDTH=2; instance "b" uses PKT_LEN=1. Each has a queue-based FIFO and a
// reference model of the expected beat stream derived from the pop order.
module tb_fifo_to_axis_packetizer;

  localparam int DW = 32;
  localparam int PL = 4;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic b_enable = 1'b0;
  logic tready = 1'b0;

  always #5 clk = ~clk;

  logic          a_rd_en, a_empty_n, a_tvalid, a_tlast, a_busy;
  logic [DW-1:0] a_rd_data, a_tdata;
  logic [CW-1:0] a_cnt;
  logic          b_rd_en, b_empty_n, b_tvalid, b_tlast, b_busy;
  logic [DW-1:0] b_rd_data, b_tdata;
  logic [15:0]   b_cnt;

  fifo_to_axis_packetizer #(.DATA_WIDTH(DW), .PKT_LEN(PL), .CNT_WIDTH(CW)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .fifo_rd_en(a_rd_en), .fifo_rd_data(a_rd_data), .fifo_empty_n(a_empty_n),
    .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tready(tready),
    .m_axis_tlast(a_tlast), .pkt_count(a_cnt), .busy(a_busy)
  );

  fifo_to_axis_packetizer #(.DATA_WIDTH(DW), .PKT_LEN(1), .CNT_WIDTH(16)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(b_enable),
    .fifo_rd_en(b_rd_en), .fifo_rd_data(b_rd_data), .fifo_empty_n(b_empty_n),
    .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tready(tready),
    .m_axis_tlast(b_tlast), .pkt_count(b_cnt), .busy(b_busy)
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] a_src[$];
  beat_t         a_exp[$];
  int            a_pops = 0;
  int            a_pkts = 0;
  int            a_beats = 0;
  int            a_beat_cyc[$];
  logic [DW-1:0] b_src[$];
  logic [DW-1:0] b_exp[$];
  int            b_pkts = 0;
  int            cyc = 0;
  bit            just_reset = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic drive();
    a_empty_n = (a_src.size() != 0);
    a_rd_data = (a_src.size() != 0) ? a_src[0] : $urandom;
    b_empty_n = (b_src.size() != 0);
    b_rd_data = (b_src.size() != 0) ? b_src[0] : $urandom;
  endtask

  // One clock: check outputs at the falling edge, advance models at the rising edge.
  task automatic step();
    logic a_pop, a_xfer, b_pop, b_xfer;
    beat_t nb;
    @(negedge clk);
    if (just_reset) begin
      chk("rst_tdata", a_tdata, 0);
      chk("rst_tlast", a_tlast, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_rd_en", a_rd_en, 0);
      chk("rst_b_busy", b_busy, 0);
    end
    chk("a_tvalid", a_tvalid, a_exp.size() != 0);
    if (a_tvalid && a_exp.size() != 0) begin
      chk("a_tdata", a_tdata, a_exp[0].d);
      chk("a_tlast", a_tlast, a_exp[0].l);
    end
    chk("a_pkt_count", a_cnt, a_pkts % (1 << CW));
    if (a_pops % PL != 0) begin
      chk("a_rd_en_mid", a_rd_en, (a_src.size() != 0) && (a_exp.size() < 2));
      chk("a_busy_mid", a_busy, 1);
    end else if (!enable) begin
      chk("a_rd_en_idle", a_rd_en, 0);
    end else if (a_rd_en) begin
      chk("a_rd_en_room", (a_src.size() != 0) && (a_exp.size() < 2), 1);
    end
    if (a_exp.size() != 0) chk("a_busy_buf", a_busy, 1);
    chk("b_tvalid", b_tvalid, b_exp.size() != 0);
    if (b_tvalid && b_exp.size() != 0) begin
      chk("b_tdata", b_tdata, b_exp[0]);
      chk("b_tlast", b_tlast, 1);
    end
    chk("b_pkt_count", b_cnt, b_pkts & 32'hFFFF);
    if (!b_enable) chk("b_rd_en_idle", b_rd_en, 0);
    else if (b_rd_en) chk("b_rd_en_room", (b_src.size() != 0) && (b_exp.size() < 2), 1);

    a_pop  = a_rd_en;
    a_xfer = a_tvalid && tready;
    b_pop  = b_rd_en;
    b_xfer = b_tvalid && tready;

    @(posedge clk);
    cyc++;
    if (a_pop && a_src.size() != 0) begin
      nb.d = a_src.pop_front();
      nb.l = (a_pops % PL) == PL - 1;
    end else begin
      nb = '0;
    end
    if (b_pop && b_src.size() != 0) b_exp.push_back(b_src.pop_front());
    else if (b_pop) b_exp.push_back('0);
    if (!reset_n) begin
      a_exp.delete();
      a_pops = 0;
      a_pkts = 0;
      b_exp.delete();
      b_pkts = 0;
      just_reset = 1'b1;
    end else begin
      just_reset = 1'b0;
      if (a_xfer && a_exp.size() != 0) begin
        if (a_exp[0].l) a_pkts++;
        void'(a_exp.pop_front());
        a_beats++;
        a_beat_cyc.push_back(cyc);
      end
      if (a_pop) begin
        a_exp.push_back(nb);
        a_pops++;
      end
      if (b_xfer && b_exp.size() != 0) begin
        b_pkts++;
        void'(b_exp.pop_front());
      end
    end
    #1;
    drive();
  endtask

  initial begin
    int p0, b0, bound;
    logic [CW-1:0] prev_cnt;
    logic [CW-1:0] seq[$];
    logic [CW-1:0] exp_seq[5];

    drive();
    // Reset
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;

    // Back-to-back packets from a preloaded FIFO; b gets 3 single-word packets
    for (int i = 0; i < 8; i++) a_src.push_back(32'h10 + i);
    for (int i = 0; i < 3; i++) b_src.push_back(32'hB0 + i);
    a_beat_cyc.delete();
    enable = 1'b1;
    b_enable = 1'b1;
    tready = 1'b1;
    drive();
    repeat (14) step();
    chk("preload_beats", a_beat_cyc.size(), 8);
    if (a_beat_cyc.size() == 8) chk("preload_consecutive", a_beat_cyc[7] - a_beat_cyc[0], 7);
    chk("preload_pkt_count", a_cnt, 2);
    chk("b_three_pkts", b_cnt, 3);

    // Enable dropped after the first pop of a packet
    for (int i = 0; i < 8; i++) a_src.push_back(32'h20 + i);
    drive();
    p0 = a_pops;
    b0 = a_beats;
    for (bound = 0; bound < 20 && a_pops == p0; bound++) step();
    chk("first_pop_seen", a_pops != p0, 1);
    enable = 1'b0;
    repeat (12) step();
    chk("no_truncate_beats", a_beats - b0, 4);
    chk("idle_fifo_left", a_src.size(), 4);
    chk("idle_rd_en", a_rd_en, 0);
    chk("idle_busy", a_busy, 0);

    // Backpressure for 5 cycles while word 2 of a packet is presented
    for (int i = 0; i < 8; i++) a_src.push_back(32'h30 + i);
    drive();
    enable = 1'b1;
    for (bound = 0; bound < 30 && !((a_beats % PL == 2) && a_exp.size() != 0); bound++) step();
    chk("word2_reached", (a_beats % PL == 2) && (a_exp.size() != 0), 1);
    tready = 1'b0;
    repeat (5) step();
    chk("occ_saturated", a_exp.size(), 2);
    tready = 1'b1;
    repeat (20) step();
    chk("stall_drained", a_src.size() + a_exp.size(), 0);

    // Reset for one cycle in the middle of a packet
    for (int i = 0; i < 8; i++) a_src.push_back(32'h40 + i);
    drive();
    for (bound = 0; bound < 30 && (a_pops % PL != 2); bound++) step();
    chk("mid_packet_reached", a_pops % PL, 2);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (15) step();

    // Packet counter wrap with CNT_WIDTH=2
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 24; i++) a_src.push_back($urandom);
    drive();
    prev_cnt = a_cnt;
    for (int i = 0; i < 40; i++) begin
      step();
      if (a_cnt != prev_cnt) seq.push_back(a_cnt);
      prev_cnt = a_cnt;
    end
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    chk("cnt_seq_len", seq.size() >= 5, 1);
    for (int i = 0; i < 5 && i < seq.size(); i++) chk($sformatf("cnt_seq[%0d]", i), seq[i], exp_seq[i]);

    // Randomized traffic, enable toggling, backpressure and occasional resets
    for (int i = 0; i < 600; i++) begin
      if (a_src.size() < 24 && $urandom_range(0, 1) == 1) a_src.push_back($urandom);
      if (b_src.size() < 24 && $urandom_range(0, 2) == 0) b_src.push_back($urandom);
      drive();
      tready   = ($urandom_range(0, 3) != 0);
      enable   = ($urandom_range(0, 7) != 0);
      b_enable = ($urandom_range(0, 4) != 0);
      reset_n  = ($urandom_range(0, 149) != 0);
      step();
    end
    reset_n = 1'b1;
    enable = 1'b0;
    tready = 1'b1;
    repeat (20) step();
    chk("final_drained", a_exp.size() + b_exp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
